// File: rtl/fader_sink_if.sv
// Output sample stream of fader_sink: valid/ready handshake carrying one
// complex sample per transfer plus its channel, frame tag and end-of-frame marker.
interface fader_sink_if #(
  parameter int W  = 16,
  parameter int TW = 25
) ();
  logic                m_valid;
  logic                m_ready;
  logic [4:0]          m_chan;
  logic signed [W-1:0] m_real;
  logic signed [W-1:0] m_imag;
  logic                m_last;
  logic [TW-1:0]       m_t_index;

  modport master (output m_valid, m_chan, m_real, m_imag, m_last, m_t_index,
                  input  m_ready);
  modport slave  (input  m_valid, m_chan, m_real, m_imag, m_last, m_t_index,
                  output m_ready);
endinterface

// File: rtl/fader_sink.sv
// Captures per-start fader bursts into a two-bank ping-pong buffer with
// channel-order checking and replays complete frames on a valid/ready stream.
module fader_sink #(
  parameter int NCHAN = 32,
  parameter int W     = 16,
  parameter int TW    = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [TW-1:0]       t_index,
  input  logic                dv_in,
  input  logic [4:0]          chan_in,
  input  logic signed [W-1:0] zc_real_in,
  input  logic signed [W-1:0] zc_imag_in,
  fader_sink_if.master        m,
  input  logic                clear_err,
  output logic                err_order,
  output logic                err_short,
  output logic                err_overflow,
  output logic                err_stray,
  output logic [15:0]         frame_count
);
  localparam int         AW   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam logic [4:0] LAST = 5'(NCHAN - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DROP} wstate_t;

  wstate_t        state, state_n;
  logic [4:0]     exp_chan, exp_chan_n;
  logic           wb, rb;
  logic [1:0]     full, iss_done;
  logic [TW-1:0]  tag [2];
  logic [2*W-1:0] mem [2**(AW+1)];
  logic           wr_en, cap_en, fill_done;
  logic           set_order, set_short, set_ovf, set_stray;

  // Write side: frame capture FSM
  always_comb begin
    state_n    = state;
    exp_chan_n = exp_chan;
    wr_en      = 1'b0;
    cap_en     = 1'b0;
    fill_done  = 1'b0;
    set_order  = 1'b0;
    set_short  = 1'b0;
    set_ovf    = 1'b0;
    set_stray  = 1'b0;
    if (start) begin
      // a start always wins over any dv_in in the same cycle
      if (state == S_FILL) set_short = 1'b1;
      if (!full[wb]) begin
        cap_en     = 1'b1;
        exp_chan_n = '0;
        state_n    = S_FILL;
      end else begin
        set_ovf = 1'b1;
        state_n = S_DROP;
      end
    end else begin
      unique case (state)
        S_IDLE: if (dv_in) set_stray = 1'b1;
        S_FILL: if (dv_in) begin
          if (chan_in == exp_chan) begin
            wr_en      = 1'b1;
            exp_chan_n = exp_chan + 5'd1;
            if (exp_chan == LAST) begin
              fill_done = 1'b1;
              state_n   = S_IDLE;
            end
          end else begin
            set_order = 1'b1;
            state_n   = S_DROP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      exp_chan <= '0;
      wb       <= 1'b0;
    end else begin
      state    <= state_n;
      exp_chan <= exp_chan_n;
      if (fill_done) wb <= ~wb;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)  mem[{wb, exp_chan[AW-1:0]}] <= {zc_real_in, zc_imag_in};
    if (cap_en) tag[wb] <= t_index;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_order    <= 1'b0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
      err_stray    <= 1'b0;
    end else begin
      err_order    <= (err_order    & ~clear_err) | set_order;
      err_short    <= (err_short    & ~clear_err) | set_short;
      err_overflow <= (err_overflow & ~clear_err) | set_ovf;
      err_stray    <= (err_stray    & ~clear_err) | set_stray;
    end
  end

  // Read side p0: issue RAM reads, at most two samples in flight beyond p0
  logic           bank_p0;
  logic [4:0]     chan_p0;
  logic           iss_en, xfer;
  logic [1:0]     occ_n;
  logic           vld_p1, last_p1;
  logic [4:0]     chan_p1;
  logic [TW-1:0]  tag_p1;
  logic [2*W-1:0] data_p1;
  logic           vld_p2, last_p2;
  logic [4:0]     chan_p2;
  logic [TW-1:0]  tag_p2;
  logic [2*W-1:0] data_p2;
  logic           skid_vld, skid_last;
  logic [4:0]     skid_chan;
  logic [TW-1:0]  skid_tag;
  logic [2*W-1:0] skid_data;

  assign xfer   = vld_p2 && m.m_ready;
  assign occ_n  = 2'(vld_p1) + 2'(vld_p2) + 2'(skid_vld) - 2'(xfer);
  assign iss_en = full[bank_p0] && !iss_done[bank_p0] && (occ_n < 2'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_p0     <= 1'b0;
      chan_p0     <= '0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      skid_vld    <= 1'b0;
      full        <= '0;
      iss_done    <= '0;
      rb          <= 1'b0;
      frame_count <= '0;
    end else begin
      vld_p1 <= iss_en;
      if (iss_en) begin
        chan_p0 <= (chan_p0 == LAST) ? 5'd0 : chan_p0 + 5'd1;
        if (chan_p0 == LAST) begin
          bank_p0           <= ~bank_p0;
          iss_done[bank_p0] <= 1'b1;
        end
      end
      if (!vld_p2 || xfer) begin
        vld_p2   <= skid_vld || vld_p1;
        skid_vld <= skid_vld && vld_p1;
      end else if (vld_p1) begin
        skid_vld <= 1'b1;
      end
      if (fill_done) full[wb] <= 1'b1;
      // the drained bank is writable from the next cycle on
      if (xfer && last_p2) begin
        full[rb]     <= 1'b0;
        iss_done[rb] <= 1'b0;
        rb           <= ~rb;
        frame_count  <= frame_count + 16'd1;
      end
    end
  end

  // p1: registered RAM read
  always_ff @(posedge clk) begin
    if (iss_en) begin
      data_p1 <= mem[{bank_p0, chan_p0[AW-1:0]}];
      chan_p1 <= chan_p0;
      last_p1 <= (chan_p0 == LAST);
      tag_p1  <= tag[bank_p0];
    end
    if ((!vld_p2 || xfer) ? (skid_vld && vld_p1) : vld_p1) begin
      skid_data <= data_p1;
      skid_chan <= chan_p1;
      skid_last <= last_p1;
      skid_tag  <= tag_p1;
    end
  end

  // p2: output register, refilled from the skid entry first to keep order
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p2 <= '0;
      chan_p2 <= '0;
      last_p2 <= 1'b0;
      tag_p2  <= '0;
    end else if (!vld_p2 || xfer) begin
      if (skid_vld) begin
        data_p2 <= skid_data;
        chan_p2 <= skid_chan;
        last_p2 <= skid_last;
        tag_p2  <= skid_tag;
      end else if (vld_p1) begin
        data_p2 <= data_p1;
        chan_p2 <= chan_p1;
        last_p2 <= last_p1;
        tag_p2  <= tag_p1;
      end
    end
  end

  assign m.m_valid   = vld_p2;
  assign m.m_chan    = chan_p2;
  assign m.m_real    = data_p2[2*W-1:W];
  assign m.m_imag    = data_p2[W-1:0];
  assign m.m_last    = vld_p2 && last_p2;
  assign m.m_t_index = tag_p2;
endmodule

// File: tb/tb_fader_sink.sv
// Randomised scoreboard bench for fader_sink: a frame-level reference model
// queues expected samples; an independent monitor checks every handshake.
module tb_fader_sink;
  localparam int NCHAN = 32;

  typedef struct packed {
    logic [4:0]  ch;
    logic        last;
    logic [24:0] tag;
    logic [15:0] re;
    logic [15:0] im;
  } smp_t;

  logic               clk;
  logic               reset;
  logic               start;
  logic [24:0]        t_index;
  logic               dv_in;
  logic [4:0]         chan_in;
  logic signed [15:0] zc_real_in;
  logic signed [15:0] zc_imag_in;
  logic               clear_err;
  logic               err_order, err_short, err_overflow, err_stray;
  logic [15:0]        frame_count;

  fader_sink_if #(.W(16), .TW(25)) bus ();

  fader_sink #(.NCHAN(NCHAN), .W(16), .TW(25)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .t_index      (t_index),
    .dv_in        (dv_in),
    .chan_in      (chan_in),
    .zc_real_in   (zc_real_in),
    .zc_imag_in   (zc_imag_in),
    .m            (bus),
    .clear_err    (clear_err),
    .err_order    (err_order),
    .err_short    (err_short),
    .err_overflow (err_overflow),
    .err_stray    (err_stray),
    .frame_count  (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   rdy_mode = 0;  // 0: ready high, 1: random, 2: ready low
  smp_t sb[$];
  smp_t part[$];
  int   md = 0;        // 0: waiting for start, 1: collecting, 2: discarding
  logic [24:0] ptag;
  int   frames_in = 0;
  int   frames_out = 0;
  bit   e_order, e_short, e_ovf, e_stray;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endfunction

  function automatic void model_reset();
    sb.delete();
    part.delete();
    md = 0;
    frames_in = 0;
    frames_out = 0;
    e_order = 0; e_short = 0; e_ovf = 0; e_stray = 0;
  endfunction

  // Frame-level reference: a frame is stored only if fewer than two undelivered frames exist.
  function automatic void model_cycle(input bit s, input logic [24:0] tg, input bit dv,
                                      input logic [4:0] ch, input logic [15:0] re,
                                      input logic [15:0] im, input bit clr);
    bit so = 0, ss = 0, sv = 0, st = 0;
    smp_t x;
    if (s) begin
      if (md == 1) ss = 1;
      part.delete();
      if (frames_in - frames_out < 2) begin
        md = 1;
        ptag = tg;
      end else begin
        sv = 1;
        md = 2;
      end
    end else if (dv) begin
      if (md == 0) st = 1;
      else if (md == 1) begin
        if (int'(ch) == part.size()) begin
          x.ch = ch; x.last = (int'(ch) == NCHAN - 1); x.tag = ptag; x.re = re; x.im = im;
          part.push_back(x);
          if (part.size() == NCHAN) begin
            foreach (part[i]) sb.push_back(part[i]);
            part.delete();
            frames_in++;
            md = 0;
          end
        end else begin
          so = 1;
          md = 2;
          part.delete();
        end
      end
    end
    if (clr) begin
      e_order = 0; e_short = 0; e_ovf = 0; e_stray = 0;
    end
    e_order |= so; e_short |= ss; e_ovf |= sv; e_stray |= st;
  endfunction

  task automatic cyc(input bit s, input logic [24:0] tg, input bit dv, input logic [4:0] ch,
                     input logic [15:0] re, input logic [15:0] im, input bit clr);
    start = s; t_index = tg; dv_in = dv; chan_in = ch;
    zc_real_in = re; zc_imag_in = im; clear_err = clr;
    model_cycle(s, tg, dv, ch, re, im, clr);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, '0, '0, 0);
  endtask

  task automatic send_frame(input logic [24:0] tg, input bit kdata, input int maxgap);
    cyc(1, tg, 0, '0, '0, '0, 0);
    for (int k = 0; k < NCHAN; k++) begin
      logic [15:0] re, im;
      if (maxgap > 0) idle($urandom_range(0, maxgap));
      re = kdata ? 16'(k)  : 16'($urandom);
      im = kdata ? 16'(-k) : 16'($urandom);
      cyc(0, tg, 1, 5'(k), re, im, 0);
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 3000; i++) begin
      if (sb.size() == 0) break;
      idle(1);
    end
    chk(nm, 64'(sb.size()), 64'd0);
    idle(4);
  endtask

  task automatic chk_flags(input string nm);
    chk(nm, {err_order, err_short, err_overflow, err_stray}, {e_order, e_short, e_ovf, e_stray});
  endtask

  // m_ready changes 2 time units after each rising edge
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake
  initial begin : monitor
    logic [63:0] held;
    logic [62:0] act;
    bit          hold_v;
    smp_t        e;
    hold_v = 0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (reset) hold_v = 0;
      else begin
        if (hold_v)
          chk("stall_stable", {bus.m_valid, bus.m_chan, bus.m_last, bus.m_t_index,
                               bus.m_real, bus.m_imag}, held);
        if (bus.m_valid && bus.m_ready) begin
          n_out++;
          act = {bus.m_chan, bus.m_last, bus.m_t_index, bus.m_real, bus.m_imag};
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got %0h required no output", act);
          end else begin
            e = sb.pop_front();
            chk("out_sample", 64'(act), 64'(e));
            if (e.last) frames_out++;
          end
        end
        hold_v = bus.m_valid && !bus.m_ready;
        held   = {bus.m_valid, bus.m_chan, bus.m_last, bus.m_t_index, bus.m_real, bus.m_imag};
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int base;
    reset = 1; start = 0; t_index = '0; dv_in = 0; chan_in = '0;
    zc_real_in = '0; zc_imag_in = '0; clear_err = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk("rst_valid_last", {bus.m_valid, bus.m_last}, 64'd0);
    chk("rst_data", {bus.m_chan, bus.m_real, bus.m_imag, bus.m_t_index}, 64'd0);
    chk("rst_flags", {err_order, err_short, err_overflow, err_stray}, 64'd0);
    chk("rst_frame_count", frame_count, 64'd0);

    // Single frame, ready high, latency from last write
    rdy_mode = 0;
    idle(2);
    base = n_out;
    send_frame(25'd5, 1, 0);
    chk("lat_edge0", bus.m_valid, 64'd0);
    idle(1);
    chk("lat_edge1", bus.m_valid, 64'd0);
    idle(1);
    chk("lat_edge2", bus.m_valid, 64'd1);
    drain("single_drain");
    chk("single_count", n_out - base, 64'd32);
    chk("single_frames", frame_count, 64'd1);
    chk("single_flags", {err_order, err_short, err_overflow, err_stray}, 64'd0);

    // Same frame under random backpressure
    rdy_mode = 1;
    base = n_out;
    send_frame(25'd6, 1, 0);
    drain("bp_drain");
    chk("bp_count", n_out - base, 64'd32);
    chk("bp_frames", frame_count, 64'd2);

    // Overflow: three frames while stalled
    rdy_mode = 2;
    idle(2);
    base = n_out;
    send_frame(25'd1, 0, 0);
    send_frame(25'd2, 0, 1);
    cyc(1, 25'd3, 0, '0, '0, '0, 0);
    chk("ovf_at_start3", err_overflow, 64'd1);
    for (int k = 0; k < NCHAN; k++) cyc(0, 25'd3, 1, 5'(k), 16'($urandom), 16'($urandom), 0);
    chk("ovf_stalled_out", n_out - base, 64'd0);
    rdy_mode = 0;
    drain("ovf_drain");
    chk("ovf_count", n_out - base, 64'd64);
    chk("ovf_frames", frame_count, 64'd4);
    chk_flags("ovf_flags");
    cyc(0, '0, 0, '0, '0, '0, 1);
    chk("ovf_clear", {err_order, err_short, err_overflow, err_stray}, 64'd0);

    // Ordering error, then short frame, then a clean frame
    base = n_out;
    cyc(1, 25'd7, 0, '0, '0, '0, 0);
    cyc(0, 25'd7, 1, 5'd0, 16'd10, 16'd20, 0);
    cyc(0, 25'd7, 1, 5'd1, 16'd11, 16'd21, 0);
    cyc(0, 25'd7, 1, 5'd3, 16'd13, 16'd23, 0);
    chk("order_flag", err_order, 64'd1);
    cyc(1, 25'd8, 0, '0, '0, '0, 0);
    for (int k = 0; k < 10; k++) cyc(0, 25'd8, 1, 5'(k), 16'($urandom), 16'($urandom), 0);
    send_frame(25'd9, 0, 0);
    chk("short_flag", err_short, 64'd1);
    drain("os_drain");
    chk("os_count", n_out - base, 64'd32);
    chk("os_frames", frame_count, 64'd5);
    chk_flags("os_flags");

    // Stray sample and clear_err, including error-wins-over-clear
    cyc(0, '0, 0, '0, '0, '0, 1);
    chk("pre_stray_clear", {err_order, err_short, err_overflow, err_stray}, 64'd0);
    cyc(0, '0, 1, 5'd4, 16'd1, 16'd2, 0);
    chk("stray_flag", {err_order, err_short, err_overflow, err_stray}, 64'b0001);
    cyc(0, '0, 1, 5'd6, 16'd1, 16'd2, 1);
    chk("stray_beats_clear", err_stray, 64'd1);
    cyc(0, '0, 0, '0, '0, '0, 1);
    chk("clear_flags", {err_order, err_short, err_overflow, err_stray}, 64'd0);

    // Reset during readout
    rdy_mode = 0;
    base = n_out;
    send_frame(25'd11, 0, 0);
    for (int i = 0; i < 300; i++) begin
      if (n_out - base >= 10) break;
      idle(1);
    end
    chk("rr_reached10", 64'(n_out - base >= 10), 64'd1);
    rdy_mode = 2;
    reset = 1;
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    chk("rr_valid", bus.m_valid, 64'd0);
    chk("rr_frames", frame_count, 64'd0);
    chk("rr_flags", {err_order, err_short, err_overflow, err_stray}, 64'd0);
    rdy_mode = 0;
    idle(2);
    base = n_out;
    send_frame(25'd12, 0, 0);
    drain("rr_drain");
    chk("rr_count", n_out - base, 64'd32);
    chk("rr_frames_after", frame_count, 64'd1);

    // Random traffic: mixed clean, misordered, short and stray bursts
    rdy_mode = 1;
    for (int it = 0; it < 40; it++) begin
      int kind, n;
      logic [24:0] tg;
      kind = $urandom_range(0, 9);
      tg   = 25'($urandom);
      case (kind)
        0: cyc(0, '0, 1, 5'($urandom), 16'($urandom), 16'($urandom), 0);
        1: begin
          n = $urandom_range(0, NCHAN - 1);
          cyc(1, tg, 0, '0, '0, '0, 0);
          for (int k = 0; k < n; k++) cyc(0, tg, 1, 5'(k), 16'($urandom), 16'($urandom), 0);
          cyc(0, tg, 1, 5'((n + 1 + $urandom_range(0, 30)) % 32), 16'($urandom), 16'($urandom), 0);
        end
        2: begin
          n = $urandom_range(0, NCHAN - 1);
          cyc(1, tg, 0, '0, '0, '0, 0);
          for (int k = 0; k < n; k++) cyc(0, tg, 1, 5'(k), 16'($urandom), 16'($urandom), 0);
        end
        default: send_frame(tg, 0, ($urandom_range(0, 3) == 0) ? 2 : 0);
      endcase
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) cyc(0, '0, 0, '0, '0, '0, 1'($urandom_range(0, 7) == 0));
      chk_flags("rand_flags");
    end
    rdy_mode = 0;
    drain("rand_drain");
    chk("rand_frames", frame_count, 64'(frames_in[15:0]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fader_sink.md
# fader_sink

Receiving end of the fader output stream. Captures each per-start burst of `dv_out`/`chan_out`/`Zc_real`/`Zc_imag` samples, checks channel ordering, stores complete frames in a two-bank ping-pong buffer tagged with the `t_index` of the frame's `start`, and replays each frame on a valid/ready stream for downstream DSP or a host DMA. It sits directly after `fader` in the hardware-test top and in the datapath, and replaces ILA-only observation with checked, flow-controlled capture.

## Interface
Parameters:
- `NCHAN`, 32, channels per frame; power of two, max 32
- `W`, 16, width of each of `Zc_real` and `Zc_imag`
- `TW`, 25, width of `t_index`

Ports:
- `clk`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  frame-start pulse, same signal that drives `fader`
- `t_index`  in  TW  frame tag; sampled in the `start` cycle
- `dv_in`  in  1  sample valid, from fader `dv_out`
- `chan_in`  in  5  sample channel, from fader `chan_out`
- `zc_real_in`, `zc_imag_in`  in  W each  sample, from fader `Zc_real`/`Zc_imag`
- `m_valid`  out  1  output sample valid
- `m_ready`  in  1  downstream accept
- `m_chan`  out  5  channel of output sample
- `m_real`, `m_imag`  out  W each  output sample
- `m_last`  out  1  high on channel `NCHAN-1`
- `m_t_index`  out  TW  tag of the frame being output
- `clear_err`  in  1  clears sticky error flags
- `err_order`, `err_short`, `err_overflow`, `err_stray`  out  1 each  sticky error flags
- `frame_count`  out  16  frames fully delivered; wraps at 2^16

## Operation
- Storage: two banks of `NCHAN` x 2W words, each with a full flag and a `t_index` tag register. Write pointer `wb` and read pointer `rb` start at bank 0.
- Write FSM states: IDLE, FILL, DROP.
  - IDLE + `start`: if bank `wb` is free, capture `t_index`, set expected channel `exp=0`, go to FILL. Otherwise set `err_overflow` and go to DROP.
  - FILL + `dv_in` with `chan_in==exp`: write the sample, then `exp++`. When the sample with `exp==NCHAN-1` is written, set full[`wb`], toggle `wb`, go to IDLE.
  - FILL + `dv_in` with `chan_in!=exp`: set `err_order`, discard the partial frame, go to DROP.
  - FILL + `start`: set `err_short` and abort the partial frame. Then apply the IDLE+`start` rule in the same cycle. Any `dv_in` in that cycle is discarded.
  - DROP: ignore `dv_in`. On `start`, apply the IDLE+`start` rule.
  - IDLE + `dv_in` without `start`: discard the sample and set `err_stray`.
- Read side runs whenever full[`rb`] is set.
  - Streams channels 0..`NCHAN-1` in order; `m_t_index` equals the tag of bank `rb`.
  - On the `m_last` handshake: clear full[`rb`], toggle `rb`, increment `frame_count`.
- Handshake: a transfer occurs when `m_valid && m_ready`. While `m_valid && !m_ready`, all `m_*` outputs hold stable. `m_valid` never deasserts without a transfer.
- A bank being read is never written. A bank becomes writable in the cycle after its last handshake.
- `clear_err` clears all four flags. If a new error occurs in the same cycle as `clear_err`, the error wins.

## Timing
- Reset values (all outputs and state): `m_valid`=0, `m_last`=0, `m_chan`/`m_real`/`m_imag`/`m_t_index`=0, all err flags=0, `frame_count`=0, FSM=IDLE, both banks empty, `wb`=`rb`=0.
- Reset mid-frame or mid-readout: state is as listed above in the cycle after `reset`; partial data is lost and no flags are set.
- Storage uses registered (1-cycle) RAM reads with an output/skid register.
- First `m_valid` rises exactly 2 cycles after the clock edge that writes channel `NCHAN-1`, if the read side is idle.
- Sustained output rate is 1 sample per cycle with `m_ready` held high, including back-to-back frames. There is no bubble between the `m_last` of bank A and channel 0 of an already-full bank B.
- Input accepts `dv_in` every cycle with no backpressure.
- The fader's 1024-cycle start period with 32-channel bursts never overflows when `m_ready`≥1/32 average duty.

## Test plan
- Single frame: `start` with `t_index`=5, then 32 `dv_in` samples (chan k, real=k, imag=-k), `m_ready`=1. Expect 32 outputs, chan 0..31, data matching, `m_last` only on chan 31, `m_t_index`=5, `frame_count`=1, no flags.
- Backpressure: same frame, `m_ready` toggles pseudo-randomly. Outputs are identical, `m_*` are stable during stalls, and there are no duplicates or drops.
- Overflow: `m_ready`=0, three frames (tags 1, 2, 3). Expect `err_overflow`=1 at the third `start`. Releasing `m_ready` yields exactly 64 samples, tags 1 then 2, `frame_count`=2.
- Ordering/short: a frame with chan sequence 0,1,3 gives `err_order` and no output for that frame. A `start` after 10 samples gives `err_short`. The following clean frame is output correctly.
- Stray/clear: `dv_in` with no `start` gives `err_stray`=1. A `clear_err` pulse returns all flags to 0 the next cycle.
- Reset mid-readout: assert `reset` at output sample 10. The next cycle shows `m_valid`=0 and `frame_count`=0, and a subsequent clean frame outputs from chan 0.
